// File: rtl/seg_scan_ctrl.sv
// Round-robin scan scheduler for a multiplexed 7-segment display with per-slot blanking,
// PWM brightness and a double-buffered pattern store committed on frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 10,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned ON_UNIT      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [3:0]            brightness,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  commit,
  output logic [7:0]            segm,
  output logic [NUM_DIGITS-1:0] sel,
  output logic                  frame_start,
  output logic                  commit_pend
);

  localparam int unsigned DigitW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW   = $clog2(BLANK_CYCLES + 15 * ON_UNIT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StOn,
    StOff
  } state_e;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [DigitW-1:0]              digit_q, digit_d;
  logic [3:0]                     br_q, br_d;

  logic [NUM_DIGITS-1:0][7:0]     shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][7:0]     active_q, active_d;
  logic                           pend_q, pend_d;

  logic [7:0]                     segm_q, segm_d;
  logic [NUM_DIGITS-1:0]          sel_q, sel_d;
  logic                           fs_q, fs_d;

  logic                           enter_blank;
  logic                           frame_boundary;
  logic [DigitW-1:0]              next_digit;
  logic [CntW-1:0]                on_len;
  logic [CntW-1:0]                off_len;
  logic                           addr_ok;

  assign next_digit = (digit_q == DigitW'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;

  // Phase lengths are loaded as "remaining cycles minus one"; each is only used when non-empty.
  assign on_len  = CntW'(32'(br_q) * ON_UNIT - 1);
  assign off_len = CntW'((32'd15 - 32'(br_q)) * ON_UNIT - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    digit_d     = digit_q;
    br_d        = br_q;
    enter_blank = 1'b0;

    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          enter_blank = 1'b1;
          digit_d     = '0;
        end
        StBlank: begin
          if (cnt_q == '0) begin
            if (br_q != 4'd0) begin
              state_d = StOn;
              cnt_d   = on_len;
            end else begin
              state_d = StOff;
              cnt_d   = CntW'(15 * ON_UNIT - 1);
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StOn: begin
          if (cnt_q == '0) begin
            if (br_q != 4'd15) begin
              state_d = StOff;
              cnt_d   = off_len;
            end else begin
              enter_blank = 1'b1;
              digit_d     = next_digit;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StOff: begin
          if (cnt_q == '0) begin
            enter_blank = 1'b1;
            digit_d     = next_digit;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          digit_d = '0;
        end
      endcase
    end

    if (enter_blank) begin
      state_d = StBlank;
      cnt_d   = CntW'(BLANK_CYCLES - 1);
      br_d    = brightness;
    end
  end

  assign frame_boundary = enter_blank && (digit_d == '0);
  assign addr_ok        = 32'(wr_addr) < NUM_DIGITS;

  // The copy reads the pre-write shadow, so a same-cycle write waits for the next commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;

    if (wr_en && addr_ok) begin
      shadow_d[wr_addr[DigitW-1:0]] = wr_data;
    end

    if (frame_boundary && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end else if (commit && !pend_q) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    segm_d = '0;
    sel_d  = '0;
    if (state_q == StOn) begin
      segm_d         = active_q[digit_q];
      sel_d[digit_q] = 1'b1;
    end
    fs_d = (state_q == StBlank) && (digit_q == '0) && (cnt_q == CntW'(BLANK_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      digit_q  <= '0;
      br_q     <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      segm_q   <= '0;
      sel_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      br_q     <= br_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      segm_q   <= segm_d;
      sel_q    <= sel_d;
      fs_q     <= fs_d;
    end
  end

  assign segm        = segm_q;
  assign sel         = sel_q;
  assign frame_start = fs_q;
  assign commit_pend = pend_q;

endmodule
